// File: rtl/hamming74_decoder.sv
// ----------------------------------------------------------------------------
// hamming74_decoder
//
// Single-error-correcting Hamming(7,4) decoder with registered outputs.
// Sits on the receive side of a link or memory path. It sits after the
// channel and before the data consumers.
//
// Codeword layout (bit index : Hamming position : role):
//   b0:1:p1  b1:2:p2  b2:3:d  b3:4:p4  b4:5:d  b5:6:d  b6:7:d
// Every check bit uses even parity.
//
// Ports:
//   clk             in   1  rising-edge clock, single clock domain
//   reset           in   1  asynchronous, active-low reset
//   hammingcode     in   7  received codeword; bit i = Hamming position i+1
//   corrected_code  out  7  registered codeword after single-bit correction
//   correctionbits  out  3  registered syndrome {s4,s2,s1}; 0 = no error
//   data_out        out  4  registered decoded data {b6,b5,b4,b2}
//   error_detected  out  1  registered; 1 when the syndrome is non-zero
//
// Latency is one cycle. A new codeword is accepted on every cycle.
// A double-bit error decodes as a wrong single-bit correction and raises
// no separate flag.
// ----------------------------------------------------------------------------
module hamming74_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] hammingcode,
    output logic [6:0] corrected_code,
    output logic [2:0] correctionbits,
    output logic [3:0] data_out,
    output logic       error_detected
);

    logic [2:0] syndrome;
    logic [6:0] flip_mask;
    logic [6:0] corrected;
    logic [3:0] data_bits;

    // Each syndrome bit is the even-parity check over the positions whose
    // Hamming index has that bit set.
    always_comb begin
        syndrome[0] = hammingcode[0] ^ hammingcode[2] ^ hammingcode[4] ^ hammingcode[6];
        syndrome[1] = hammingcode[1] ^ hammingcode[2] ^ hammingcode[5] ^ hammingcode[6];
        syndrome[2] = hammingcode[3] ^ hammingcode[4] ^ hammingcode[5] ^ hammingcode[6];
    end

    // A non-zero syndrome names the Hamming position (index + 1) to invert.
    always_comb begin
        flip_mask = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            if (syndrome == 3'(i + 1)) begin
                flip_mask[i] = 1'b1;
            end
        end
    end

    always_comb begin
        corrected = hammingcode ^ flip_mask;
        data_bits = {corrected[6], corrected[5], corrected[4], corrected[2]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            corrected_code <= '0;
            correctionbits <= '0;
            data_out       <= '0;
            error_detected <= 1'b0;
        end else begin
            corrected_code <= corrected;
            correctionbits <= syndrome;
            data_out       <= data_bits;
            error_detected <= |syndrome;
        end
    end

endmodule

// File: tb/tb_hamming74_decoder.sv
module tb_hamming74_decoder;

    logic       clk;
    logic       reset;
    logic [6:0] hammingcode;
    logic [6:0] corrected_code;
    logic [2:0] correctionbits;
    logic [3:0] data_out;
    logic       error_detected;

    int total;
    int bad;

    hamming74_decoder dut (
        .clk            (clk),
        .reset          (reset),
        .hammingcode    (hammingcode),
        .corrected_code (corrected_code),
        .correctionbits (correctionbits),
        .data_out       (data_out),
        .error_detected (error_detected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The syndrome is the XOR of the 1-based positions of all set bits.
    function automatic logic [2:0] ref_syndrome(input logic [6:0] c);
        int s;
        s = 0;
        for (int i = 0; i < 7; i++)
            if (c[i]) s = s ^ (i + 1);
        return 3'(s);
    endfunction

    // The data goes to positions 3,5,6,7. Each parity bit at position k
    // cancels the k component of the syndrome.
    function automatic logic [6:0] ref_encode(input logic [3:0] d);
        logic [6:0] c;
        logic [2:0] s;
        c = '0;
        c[2] = d[0];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        s = ref_syndrome(c);
        if (s[0]) c[0] = 1'b1;
        if (s[1]) c[1] = 1'b1;
        if (s[2]) c[3] = 1'b1;
        return c;
    endfunction

    // Expected packed outputs {corrected, syndrome, data, error}.
    function automatic logic [14:0] ref_decode(input logic [6:0] c);
        logic [2:0] s;
        logic [6:0] k;
        s = ref_syndrome(c);
        k = c;
        if (s != 0) k[int'(s) - 1] = ~k[int'(s) - 1];
        return {k, s, k[6], k[5], k[4], k[2], (s != 0)};
    endfunction

    function automatic logic [14:0] observed();
        return {corrected_code, correctionbits, data_out, error_detected};
    endfunction

    task automatic test_reset();
        hammingcode = 7'($urandom);
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (observed() !== 15'd0) begin
            bad++;
            $display("FAIL reset_async got=%h want=%h", observed(), 15'd0);
        end
        @(posedge clk);
        #1;
        total++;
        if (observed() !== 15'd0) begin
            bad++;
            $display("FAIL reset_hold got=%h want=%h", observed(), 15'd0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_directed();
        logic [6:0]  codes [5];
        logic [2:0]  syns  [5];
        logic [14:0] want;
        codes[0] = 7'b1010101; syns[0] = 3'b000;
        codes[1] = 7'b1010100; syns[1] = 3'b001;
        codes[2] = 7'b1010111; syns[2] = 3'b010;
        codes[3] = 7'b1000101; syns[3] = 3'b101;
        codes[4] = 7'b0010101; syns[4] = 3'b111;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            hammingcode = codes[i];
            @(posedge clk);
            #1;
            want = {7'b1010101, syns[i], 4'b1011, (syns[i] != 3'b000)};
            total++;
            if (observed() !== want) begin
                bad++;
                $display("FAIL directed[%0d] in=%b got=%h want=%h", i, codes[i], observed(), want);
            end
        end
    endtask

    task automatic test_sweep();
        logic [6:0]  clean;
        logic [6:0]  code;
        logic [14:0] want;
        for (int d = 0; d < 16; d++) begin
            for (int e = 0; e < 8; e++) begin
                clean = ref_encode(4'(d));
                code  = clean;
                if (e != 0) code[e - 1] = ~code[e - 1];
                @(negedge clk);
                hammingcode = code;
                @(posedge clk);
                #1;
                want = {clean, 3'(e), 4'(d), (e != 0)};
                total++;
                if (observed() !== want) begin
                    bad++;
                    $display("FAIL sweep d=%0d pos=%0d got=%h want=%h", d, e, observed(), want);
                end
            end
        end
    endtask

    // A new codeword goes in on every negedge. At each later negedge the
    // outputs must show the decode of exactly the previous input.
    task automatic test_back_to_back();
        logic [6:0] prev;
        logic [6:0] cur;
        @(negedge clk);
        prev = 7'($urandom);
        hammingcode = prev;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            total++;
            if (observed() !== ref_decode(prev)) begin
                bad++;
                $display("FAIL back_to_back[%0d] in=%b got=%h want=%h", i, prev, observed(), ref_decode(prev));
            end
            cur = 7'($urandom);
            hammingcode = cur;
            prev = cur;
        end
    endtask

    task automatic test_mid_reset();
        logic [6:0] a;
        logic [6:0] b;
        a = 7'($urandom);
        b = 7'($urandom);
        @(negedge clk);
        hammingcode = a;
        @(posedge clk);
        #1;
        total++;
        if (observed() !== ref_decode(a)) begin
            bad++;
            $display("FAIL midreset_pre got=%h want=%h", observed(), ref_decode(a));
        end
        @(negedge clk);
        hammingcode = b;
        #2;
        reset = 1'b0;
        #1;
        total++;
        if (observed() !== 15'd0) begin
            bad++;
            $display("FAIL midreset_drop got=%h want=%h", observed(), 15'd0);
        end
        @(posedge clk);
        #1;
        total++;
        if (observed() !== 15'd0) begin
            bad++;
            $display("FAIL midreset_discard got=%h want=%h", observed(), 15'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++;
        if (observed() !== 15'd0) begin
            bad++;
            $display("FAIL midreset_release got=%h want=%h", observed(), 15'd0);
        end
        @(posedge clk);
        #1;
        total++;
        if (observed() !== ref_decode(b)) begin
            bad++;
            $display("FAIL midreset_resume got=%h want=%h", observed(), ref_decode(b));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        hammingcode = '0;
        test_reset();
        test_directed();
        test_sweep();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
